reg_bank_ctrl: RTL



---
 rtl/reg_bank_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/reg_bank_ctrl.sv
// -----------------------------------------------------------------------------
// reg_bank_ctrl
//   Parametrised control-register bank behind a sel/wr/ready slave handshake.
//   Writes are byte-strobed and complete in the accepting cycle. Reads complete
//   RD_LATENCY cycles after acceptance with a one-cycle rvalid pulse. Indices
//   RO_BASE..DEPTH-1 are read-only. Writes to the read-only region, writes
//   beyond DEPTH and reads beyond DEPTH raise a one-cycle err pulse.
//
// Ports
//   clk    : clock, all logic on posedge
//   rst_n  : synchronous active-low reset
//   sel    : access request
//   wr     : 1 = write, 0 = read (sampled with sel)
//   addr   : register index
//   wdata  : write data
//   wstrb  : byte enables, bit k covers wdata[8k+7:8k]
//   ready  : an access presented this cycle will be accepted
//   rdata  : read data, zero whenever rvalid = 0
//   rvalid : one-cycle read-completion pulse
//   err    : one-cycle illegal-access pulse
// -----------------------------------------------------------------------------
module reg_bank_ctrl #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 256,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL = DATA_WIDTH'(16'h1234),
   parameter int RO_BASE    = 240,
   parameter int RD_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    sel,
   input  logic                    wr,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    ready,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic                    rvalid,
   output logic                    err
);

   localparam int NBYTES = DATA_WIDTH / 8;
   // RD_WAIT runs for RD_LATENCY-1 cycles; the counter holds the remaining
   // wait cycles minus one so that "counter == 0" marks the last wait cycle.
   localparam logic [2:0] CNT_LOAD = (RD_LATENCY > 1) ? 3'(RD_LATENCY - 2) : 3'd0;

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      RD_RESP
   } state_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   state_t                state_reg, state_next;
   logic [2:0]            cnt_reg, cnt_next;
   logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
   logic                  ready_reg, ready_next;
   logic                  rvalid_reg, rvalid_next;
   logic                  err_reg, err_next;
   logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;

   logic                  we;
   logic                  in_range, writable, q_in_range;
   logic [DATA_WIDTH-1:0] cur_word, q_word, wmerge;

   // Full-width compares: out-of-range indices never alias onto real registers.
   assign in_range   = 32'(addr) < 32'(DEPTH);
   assign writable   = 32'(addr) < 32'(RO_BASE);
   assign q_in_range = 32'(addr_reg) < 32'(DEPTH);

   assign cur_word = in_range   ? mem[addr]     : '0;
   assign q_word   = q_in_range ? mem[addr_reg] : '0;

   // Byte merge: strobed bytes take wdata, the rest keep the stored value.
   for (genvar gi = 0; gi < NBYTES; gi++) begin : g_merge
      assign wmerge[gi*8 +: 8] = wstrb[gi] ? wdata[gi*8 +: 8] : cur_word[gi*8 +: 8];
   end

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      addr_next   = addr_reg;
      ready_next  = 1'b1;
      rvalid_next = 1'b0;
      rdata_next  = '0;
      err_next    = 1'b0;
      we          = 1'b0;
      case (state_reg)
         RD_WAIT: begin
            if (cnt_reg == 3'd0) begin
               state_next  = RD_RESP;
               rvalid_next = 1'b1;
               rdata_next  = q_word;
               err_next    = !q_in_range;
            end else begin
               cnt_next   = cnt_reg - 3'd1;
               ready_next = 1'b0;
            end
         end
         default: begin
            // IDLE and RD_RESP both have ready=1, so both accept accesses.
            state_next = IDLE;
            if (sel) begin
               if (wr) begin
                  if (writable) we = |wstrb;
                  else          err_next = 1'b1;
               end else begin
                  addr_next = addr;
                  if (RD_LATENCY == 1) begin
                     state_next  = RD_RESP;
                     rvalid_next = 1'b1;
                     rdata_next  = cur_word;
                     err_next    = !in_range;
                  end else begin
                     state_next = RD_WAIT;
                     cnt_next   = CNT_LOAD;
                     ready_next = 1'b0;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         cnt_reg    <= 3'd0;
         addr_reg   <= '0;
         ready_reg  <= 1'b1;
         rvalid_reg <= 1'b0;
         rdata_reg  <= '0;
         err_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         addr_reg   <= addr_next;
         ready_reg  <= ready_next;
         rvalid_reg <= rvalid_next;
         rdata_reg  <= rdata_next;
         err_reg    <= err_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
      end else if (we) begin
         mem[addr] <= wmerge;
      end
   end

   assign ready  = ready_reg;
   assign rdata  = rdata_reg;
   assign rvalid = rvalid_reg;
   assign err    = err_reg;

endmodule
